// File: rtl/udp_frame_rx_check.sv
// GMII receive parser: filters Ethernet/IPv4/UDP headers, packs payload big-endian into RAM words, checks FCS.
// Inputs registered once; RAM writes one cycle after the 4th (or last) payload byte; status one cycle after CHECK; no backpressure.
module udp_frame_rx_check #(
    parameter logic [47:0] BOARD_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] BOARD_IP   = 32'hC0A80002,
    parameter logic [15:0] BOARD_PORT = 16'd8080,
    parameter int          ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        e_rxd,
    input  logic              e_rxdv,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [31:0]       ram_wr_data,
    output logic [15:0]       rx_data_length,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              frame_drop,
    output logic              busy,
    output logic [3:0]        rx_state
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_PRE = 4'd1, S_ETH = 4'd2, S_IP = 4'd3, S_UDP = 4'd4,
        S_PAY = 4'd5, S_TAIL = 4'd6, S_CHECK = 4'd7, S_DROP = 4'd8, S_SKIP = 4'd9
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_rxd;
    logic              r_rxdv;
    logic              r_pre_ok;
    logic [16:0]       r_cnt;
    logic [16:0]       r_need;
    logic [39:0]       r_sh;
    logic [31:0]       r_crc;
    logic [15:0]       r_len;
    logic [15:0]       r_left;
    logic              r_err;
    logic [31:0]       r_word;
    logic [1:0]        r_bsel;
    logic [ADDR_W:0]   r_wcnt;

    logic [47:0]       w_sh;
    logic [15:0]       w_udp_len;
    logic [31:0]       w_crc_nxt;
    logic [31:0]       w_word;
    logic              w_filt_fail;
    logic              w_pulse_ok, w_pulse_err, w_pulse_drop;
    logic              w_in_frame;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++)
            x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign w_sh       = {r_sh, r_rxd};
    assign w_udp_len  = w_sh[15:0];
    assign w_crc_nxt  = crc_byte(r_crc, r_rxd);
    assign w_in_frame = (r_state == S_ETH) || (r_state == S_IP) || (r_state == S_UDP) ||
                        (r_state == S_PAY) || (r_state == S_TAIL);
    assign busy       = w_in_frame || (r_state == S_CHECK) || (r_state == S_DROP);
    assign rx_state   = r_state;

    always_comb begin
        w_word = {r_word[31:8], r_rxd};
        case (r_bsel)
            2'd0:    w_word = {r_rxd, 24'h0};
            2'd1:    w_word = {r_word[31:24], r_rxd, 16'h0};
            2'd2:    w_word = {r_word[31:16], r_rxd, 8'h0};
            default: w_word = {r_word[31:8], r_rxd};
        endcase
    end

    // Header byte offsets are counted from the first destination-MAC byte.
    always_comb begin
        w_filt_fail = 1'b0;
        case (r_cnt)
            17'd5:   w_filt_fail = (w_sh != BOARD_MAC) && (w_sh != 48'hFFFFFFFFFFFF);
            17'd13:  w_filt_fail = (w_sh[15:0] != 16'h0800);
            17'd14:  w_filt_fail = (r_rxd != 8'h45);
            17'd23:  w_filt_fail = (r_rxd != 8'd17);
            17'd33:  w_filt_fail = (w_sh[31:0] != BOARD_IP);
            17'd37:  w_filt_fail = (w_sh[15:0] != BOARD_PORT);
            default: w_filt_fail = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pulse_ok   = 1'b0;
        w_pulse_err  = 1'b0;
        w_pulse_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A byte arriving alongside a status pulse belongs to a frame that started too early.
                if (r_rxdv) begin
                    if (frame_ok || frame_err || frame_drop) w_state_nxt = S_SKIP;
                    else if (r_rxd == 8'h55)                 w_state_nxt = S_PRE;
                    else                                     w_state_nxt = S_SKIP;
                end
            end
            S_PRE: begin
                if (!r_rxdv)                           w_state_nxt = S_IDLE;
                else if (r_rxd == 8'hD5 && r_pre_ok)   w_state_nxt = S_ETH;
                else if (r_rxd != 8'h55)               w_state_nxt = S_SKIP;
            end
            S_ETH, S_IP, S_UDP: begin
                if (!r_rxdv)               w_state_nxt = S_CHECK;
                else if (w_filt_fail)      w_state_nxt = S_DROP;
                else if (r_cnt == 17'd13)  w_state_nxt = S_IP;
                else if (r_cnt == 17'd33)  w_state_nxt = S_UDP;
                else if (r_cnt == 17'd41)  w_state_nxt = (r_len == 16'd0) ? S_TAIL : S_PAY;
            end
            S_PAY: begin
                if (!r_rxdv)                w_state_nxt = S_CHECK;
                else if (r_left == 16'd1)   w_state_nxt = S_TAIL;
            end
            S_TAIL: if (!r_rxdv) w_state_nxt = S_CHECK;
            S_CHECK: begin
                w_pulse_ok  = (r_crc == 32'hDEBB20E3) && !r_err;
                w_pulse_err = !w_pulse_ok;
                w_state_nxt = r_rxdv ? S_SKIP : S_IDLE;
            end
            S_DROP: begin
                if (!r_rxdv) begin
                    w_pulse_drop = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_SKIP:  if (!r_rxdv) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd <= '0; r_rxdv <= 1'b0; r_pre_ok <= 1'b0;
            r_cnt <= '0; r_need <= '0; r_sh <= '0; r_crc <= '0;
            r_len <= '0; r_left <= '0; r_err <= 1'b0;
            r_word <= '0; r_bsel <= '0; r_wcnt <= '0;
            ram_wr_en <= 1'b0; ram_wr_addr <= '0; ram_wr_data <= '0;
            rx_data_length <= '0;
            frame_ok <= 1'b0; frame_err <= 1'b0; frame_drop <= 1'b0;
        end else begin
            r_rxd      <= e_rxd;
            r_rxdv     <= e_rxdv;
            ram_wr_en  <= 1'b0;
            frame_ok   <= w_pulse_ok;
            frame_err  <= w_pulse_err;
            frame_drop <= w_pulse_drop;

            if (r_state == S_IDLE) r_pre_ok <= 1'b0;
            if (r_state == S_PRE && r_rxdv && r_rxd == 8'h55) r_pre_ok <= 1'b1;

            if (r_state == S_PRE && w_state_nxt == S_ETH) begin
                r_cnt <= '0; r_crc <= 32'hFFFFFFFF; r_err <= 1'b0;
                r_wcnt <= '0; r_bsel <= '0; r_len <= '0; ram_wr_addr <= '0;
            end

            if (w_in_frame && r_rxdv) begin
                r_crc <= w_crc_nxt;
                r_cnt <= r_cnt + 17'd1;
                r_sh  <= w_sh[39:0];
            end

            if ((r_state == S_ETH || r_state == S_IP || r_state == S_UDP) && !r_rxdv)
                r_err <= 1'b1;

            if (r_state == S_UDP && r_rxdv && r_cnt == 17'd39) begin
                if (w_udp_len < 16'd8) begin
                    r_err <= 1'b1;
                    r_len <= '0;
                end else begin
                    r_len <= w_udp_len - 16'd8;
                end
            end

            if (r_state == S_UDP && r_rxdv && r_cnt == 17'd41) begin
                rx_data_length <= r_len;
                r_left         <= r_len;
                r_need         <= {1'b0, r_len} + 17'd46;
            end

            if (r_state == S_PAY && r_rxdv) begin
                r_left <= r_left - 16'd1;
                r_word <= w_word;
                r_bsel <= r_bsel + 2'd1;
                if (r_bsel == 2'd3 || r_left == 16'd1) begin
                    if (r_wcnt[ADDR_W]) begin
                        r_err <= 1'b1;
                    end else begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= r_wcnt[ADDR_W-1:0];
                        ram_wr_data <= w_word;
                        r_wcnt      <= r_wcnt + 1'b1;
                    end
                end
            end

            // Frame must carry the full payload plus four FCS bytes.
            if ((r_state == S_PAY || r_state == S_TAIL) && !r_rxdv && r_cnt < r_need)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_udp_frame_rx_check.sv
// Directed frames through the receive checker; expected RAM writes and status codes are queued and popped by a monitor.
module tb_udp_frame_rx_check;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  e_rxd;
    logic        e_rxdv;
    logic        ram_wr_en;
    logic [8:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [15:0] rx_data_length;
    logic        frame_ok, frame_err, frame_drop, busy;
    logic [3:0]  rx_state;

    localparam logic [47:0] MAC  = 48'h000A3501FEC0;
    localparam logic [31:0] IP   = 32'hC0A80002;
    localparam logic [15:0] PORT = 16'd8080;
    localparam int ST_OK = 1, ST_ERR = 2, ST_DROP = 3;

    udp_frame_rx_check dut (
        .clk(clk), .reset(reset), .e_rxd(e_rxd), .e_rxdv(e_rxdv),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .rx_data_length(rx_data_length), .frame_ok(frame_ok), .frame_err(frame_err),
        .frame_drop(frame_drop), .busy(busy), .rx_state(rx_state)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
    wr_t        exp_wr[$];
    int         exp_st[$];
    logic [7:0] pay[$];
    logic [7:0] frm[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            c = c ^ {31'b0, d[i]};
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Monitor: pops expectations whenever the DUT writes RAM or pulses status.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (ram_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {23'b0, ram_wr_addr, ram_wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", {55'b0, ram_wr_addr}, {55'b0, w.addr});
                    chk("wr_data", {32'b0, ram_wr_data}, {32'b0, w.data});
                end
            end
            if (frame_ok || frame_err || frame_drop) begin
                int code;
                chk("status_onehot", $countones({frame_ok, frame_err, frame_drop}), 1);
                code = frame_drop ? ST_DROP : (frame_err ? ST_ERR : ST_OK);
                if (exp_st.size() == 0) chk("unexpected_status", code, 0);
                else                    chk("status", code, exp_st.pop_front());
            end
        end
    end

    task automatic exp_w(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = a[8:0];
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] etype, input logic [15:0] port,
                         input int flip);
        logic [7:0]  b[$];
        logic [31:0] c;
        logic [15:0] ulen, tlen;
        logic [31:0] src_ip;
        ulen   = 16'(pay.size() + 8);
        tlen   = ulen + 16'd20;
        src_ip = 32'hC0A80001;
        for (int i = 5; i >= 0; i--) b.push_back(mac[8*i +: 8]);
        b.push_back(8'h02); for (int i = 0; i < 4; i++) b.push_back(8'h00); b.push_back(8'h01);
        b.push_back(etype[15:8]); b.push_back(etype[7:0]);
        b.push_back(8'h45); b.push_back(8'h00); b.push_back(tlen[15:8]); b.push_back(tlen[7:0]);
        b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
        b.push_back(8'h40); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(IP[8*i +: 8]);
        b.push_back(8'h04); b.push_back(8'hD2); b.push_back(port[15:8]); b.push_back(port[7:0]);
        b.push_back(ulen[15:8]); b.push_back(ulen[7:0]); b.push_back(8'h00); b.push_back(8'h00);
        foreach (pay[i]) b.push_back(pay[i]);
        while (b.size() < 60) b.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (b[i]) c = crc_upd(c, b[i]);
        c = ~c;
        b.push_back(c[7:0]); b.push_back(c[15:8]); b.push_back(c[23:16]); b.push_back(c[31:24]);
        if (flip >= 0) b[42 + flip] = b[42 + flip] ^ 8'h01;
        frm.delete();
        for (int i = 0; i < 7; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        foreach (b[i]) frm.push_back(b[i]);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            e_rxdv = 1'b1;
            e_rxd  = frm[i];
        end
        @(posedge clk); #1;
        e_rxdv = 1'b0;
        e_rxd  = 8'h00;
        repeat (12) @(posedge clk);
    endtask

    task automatic send();
        send_n(frm.size());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_st.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_wr.size() + exp_st.size(), 0);
    endtask

    task automatic pay_1_10();
        pay.delete();
        for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
    endtask

    task automatic exp_frame_a();
        exp_w(0, 32'h01020304); exp_w(1, 32'h05060708); exp_w(2, 32'h090A0000);
        exp_st.push_back(ST_OK);
    endtask

    initial begin
        reset  = 1'b1;
        e_rxd  = 8'h00;
        e_rxdv = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {ram_wr_en, ram_wr_addr, ram_wr_data, rx_data_length,
                              frame_ok, frame_err, frame_drop, busy, rx_state}, 64'h0);

        pay_1_10();
        build(MAC, 16'h0800, PORT, -1);
        exp_frame_a();
        send();
        drain("drain_good");
        chk("len_good", rx_data_length, 16'd10);

        build(MAC, 16'h0800, PORT, 9);
        exp_w(0, 32'h01020304); exp_w(1, 32'h05060708); exp_w(2, 32'h090B0000);
        exp_st.push_back(ST_ERR);
        send();
        drain("drain_bitflip");

        build(MAC, 16'h0800, 16'd8081, -1);
        exp_st.push_back(ST_DROP);
        send();
        drain("drain_port");
        build(48'h000000000001, 16'h0800, PORT, -1);
        exp_st.push_back(ST_DROP);
        send();
        drain("drain_mac");
        build(MAC, 16'h0806, PORT, -1);
        exp_st.push_back(ST_DROP);
        send();
        drain("drain_etype");

        pay.delete();
        pay.push_back(8'hAA); pay.push_back(8'hBB); pay.push_back(8'hCC); pay.push_back(8'hDD);
        build(48'hFFFFFFFFFFFF, 16'h0800, PORT, -1);
        exp_w(0, 32'hAABBCCDD);
        exp_st.push_back(ST_OK);
        send();
        drain("drain_pad");
        chk("len_pad", rx_data_length, 16'd4);

        pay.delete();
        for (int i = 0; i < 2100; i++) pay.push_back(8'(i));
        build(MAC, 16'h0800, PORT, -1);
        for (int k = 0; k < 512; k++)
            exp_w(k, {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
        exp_st.push_back(ST_ERR);
        send();
        drain("drain_overflow");
        chk("len_overflow", rx_data_length, 16'd2100);

        pay_1_10();
        build(MAC, 16'h0800, PORT, -1);
        exp_w(0, 32'h01020304);
        for (int i = 0; i < 56; i++) begin
            @(posedge clk); #1;
            e_rxdv = 1'b1;
            e_rxd  = frm[i];
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 e_rxdv = 1'b0; e_rxd = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_midframe_state", {busy, rx_state}, 5'd0);
        exp_frame_a();
        send();
        drain("drain_after_reset");

        exp_st.push_back(ST_ERR);
        send_n(27);
        drain("drain_trunc_ip");

        exp_frame_a();
        exp_frame_a();
        send();
        send();
        drain("drain_back_to_back");

        chk("end_queues", exp_wr.size() + exp_st.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
